// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   CPU-side initiator for a word-indexed data memory. Accepts RV32I load and
//   store requests (byte address + funct3), drives MEMR/MEMW/MEM_ADDRESS/
//   MEM_DATA_W, extracts and extends load lanes, and performs read-modify-write
//   for SB/SH. Misaligned, out-of-range and illegal requests complete with a
//   fault and never touch memory.
//
// Ports
//   CLK, RST_N     clock (rising edge), asynchronous active-low reset
//   LS_REQ         request valid, accepted when LS_READY=1
//   LS_WE          1 = store, 0 = load
//   LS_FUNCT3      RV32I funct3
//   LS_ADDR        byte address
//   LS_WDATA       store data (low byte/half used for SB/SH)
//   LS_READY       unit idle
//   LS_VALID       one-cycle completion pulse
//   LS_RDATA       extended load result (valid with LS_VALID)
//   LS_FAULT       request rejected (valid with LS_VALID)
//   MEMR, MEMW     memory read / write enables
//   MEM_ADDRESS    word index of the captured address
//   MEM_DATA_W     write word
//   MEM_DATA_R     memory read data (combinational from memory)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LS_REQ,
    input  logic        LS_WE,
    input  logic [2:0]  LS_FUNCT3,
    input  logic [31:0] LS_ADDR,
    input  logic [31:0] LS_WDATA,
    output logic        LS_READY,
    output logic        LS_VALID,
    output logic [31:0] LS_RDATA,
    output logic        LS_FAULT,
    output logic        MEMR,
    output logic        MEMW,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_DATA_W,
    input  logic [31:0] MEM_DATA_R
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        fault_q, fault_d;

    logic        acc_fault;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the target byte/half of the old word for SB/SH.
    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        r = old;
        if (f3 == 3'b000) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            r[31:16] = wdata[15:0];
        end else begin
            r[15:0] = wdata[15:0];
        end
        return r;
    endfunction

    // Fault classification of the request presented at the accept edge.
    always_comb begin
        logic legal;
        logic mis;
        if (LS_WE) begin
            legal = (LS_FUNCT3 == 3'b000) || (LS_FUNCT3 == 3'b001) ||
                    (LS_FUNCT3 == 3'b010);
        end else begin
            legal = (LS_FUNCT3 == 3'b000) || (LS_FUNCT3 == 3'b001) ||
                    (LS_FUNCT3 == 3'b010) || (LS_FUNCT3 == 3'b100) ||
                    (LS_FUNCT3 == 3'b101);
        end
        // funct3[1:0] encodes the access size for every legal code.
        mis = ((LS_FUNCT3[1:0] == 2'b01) && LS_ADDR[0]) ||
              ((LS_FUNCT3[1:0] == 2'b10) && (LS_ADDR[1:0] != 2'b00));
        acc_fault = !legal || mis || ({2'b00, LS_ADDR[31:2]} >= DEPTH_W);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (LS_REQ) begin
                    we_d     = LS_WE;
                    funct3_d = LS_FUNCT3;
                    addr_d   = LS_ADDR;
                    wdata_d  = LS_WDATA;
                    word_d   = 32'h0;
                    fault_d  = acc_fault;
                    if (acc_fault) begin
                        state_d = S_RESP;
                    end else if (!LS_WE) begin
                        state_d = S_RD;
                    end else if (LS_FUNCT3 == 3'b010) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                word_d  = MEM_DATA_R;
                state_d = S_RESP;
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                word_d  = MEM_DATA_R;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            fault_q  <= fault_d;
        end
    end

    // Every output below depends only on registered state and captured values.
    always_comb begin
        LS_READY    = (state_q == S_IDLE);
        LS_VALID    = (state_q == S_RESP);
        LS_FAULT    = (state_q == S_RESP) && fault_q;
        LS_RDATA    = 32'h0;
        MEMR        = (state_q == S_RD) || (state_q == S_RMW_RD);
        MEMW        = (state_q == S_WR) || (state_q == S_RMW_WR);
        MEM_ADDRESS = 32'h0;
        MEM_DATA_W  = 32'h0;
        if (state_q != S_IDLE) begin
            MEM_ADDRESS = {2'b00, addr_q[31:2]};
        end
        if (state_q == S_WR) begin
            MEM_DATA_W = wdata_q;
        end else if (state_q == S_RMW_WR) begin
            MEM_DATA_W = store_merge(funct3_q, addr_q[1:0], word_q, wdata_q);
        end
        if ((state_q == S_RESP) && !fault_q && !we_q) begin
            LS_RDATA = load_extend(funct3_q, addr_q[1:0], word_q);
        end
    end

endmodule
